// File: rtl/pdp8_bus_if.sv
// Request/response and pin bundle between the PDP-8 sequencer, the nibble
// bus master and the io_out/io_in pins.
interface pdp8_bus_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_io;
    logic [11:0] req_addr;
    logic [4:0]  req_dev;
    logic [11:0] req_wdata;
    logic        resp_valid;
    logic [11:0] resp_rdata;
    logic        resp_skip;
    logic        resp_err;
    logic        irq;
    logic [7:0]  bus_out;
    logic [3:0]  bus_din;

    modport master (
        input  req_valid, req_we, req_io, req_addr, req_dev, req_wdata, bus_din,
        output req_ready, resp_valid, resp_rdata, resp_skip, resp_err, irq, bus_out
    );

    modport slave (
        output req_valid, req_we, req_io, req_addr, req_dev, req_wdata, bus_din,
        input  req_ready, resp_valid, resp_rdata, resp_skip, resp_err, irq, bus_out
    );
endinterface

// File: rtl/pdp8_bus_master.sv
// CPU-side initiator for the 8-pin nibble-multiplexed PDP-8 memory/IO bus:
// one 12-bit request becomes address, optional IO select, status poll and data nibbles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, bus_out = IDLE_OUT
// AHI    | address high six bits, sample interrupt
// ALO    | address low six bits, sample interrupt
// IOSEL  | IO device select (IO transactions only)
// STAT   | status poll: ready / skip, counts not-ready cycles
// RD0-2  | read data nibbles, high to low
// WR0-2  | write data nibbles, low to high; WR2 commits
// DONE   | one-cycle response pulse
module pdp8_bus_master #(
    parameter int unsigned MAX_POLL = 15,
    parameter logic [7:0]  IDLE_OUT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    pdp8_bus_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_AHI, S_ALO, S_IOSEL, S_STAT,
        S_RD0, S_RD1, S_RD2, S_WR0, S_WR1, S_WR2, S_DONE
    } state_t;

    localparam int PW = (MAX_POLL > 0) ? $clog2(MAX_POLL + 1) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLL);

    state_t        state, state_nxt;
    logic          we_q, io_q;
    logic [5:0]    addr_lo_q;
    logic [4:0]    dev_q;
    logic [11:0]   wdata_q;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    rd_hi;
    logic [7:0]    bus_out_nxt;
    logic          accept;
    logic          bus_ready;

    assign bus.req_ready = (state == S_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus_ready     = bus.bus_din[1];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_AHI;
            S_AHI:   state_nxt = S_ALO;
            S_ALO:   state_nxt = io_q ? S_IOSEL : S_STAT;
            S_IOSEL: state_nxt = S_STAT;
            S_STAT: begin
                if (bus_ready)
                    state_nxt = we_q ? S_WR0 : S_RD0;
                else if (poll_cnt == POLL_LAST)
                    state_nxt = S_DONE;
            end
            S_RD0:   state_nxt = S_RD1;
            S_RD1:   state_nxt = S_RD2;
            S_RD2:   state_nxt = S_DONE;
            S_WR0:   state_nxt = S_WR1;
            S_WR1:   state_nxt = S_WR2;
            S_WR2:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // bus_out is registered from the next state so it lines up with the state itself
        bus_out_nxt = IDLE_OUT;
        case (state_nxt)
            S_AHI:   bus_out_nxt = {2'b11, bus.req_addr[11:6]};
            S_ALO:   bus_out_nxt = {2'b10, addr_lo_q};
            S_IOSEL: bus_out_nxt = {3'b011, dev_q};
            S_STAT:  bus_out_nxt = 8'h60;
            S_RD0:   bus_out_nxt = 8'h00;
            S_RD1:   bus_out_nxt = 8'h20;
            S_RD2:   bus_out_nxt = 8'h40;
            S_WR0:   bus_out_nxt = {4'b0001, wdata_q[3:0]};
            S_WR1:   bus_out_nxt = {4'b0011, wdata_q[7:4]};
            S_WR2:   bus_out_nxt = {4'b0101, wdata_q[11:8]};
            default: bus_out_nxt = IDLE_OUT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.bus_out    <= IDLE_OUT;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 12'h000;
            bus.resp_skip  <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.irq        <= 1'b0;
            poll_cnt       <= '0;
            we_q           <= 1'b0;
            io_q           <= 1'b0;
            addr_lo_q      <= 6'h00;
            dev_q          <= 5'h00;
            wdata_q        <= 12'h000;
            rd_hi          <= 8'h00;
        end else begin
            state          <= state_nxt;
            bus.bus_out    <= bus_out_nxt;
            bus.resp_valid <= (state_nxt == S_DONE);

            if (accept) begin
                we_q      <= bus.req_we;
                io_q      <= bus.req_io;
                addr_lo_q <= bus.req_addr[5:0];
                dev_q     <= bus.req_dev;
                wdata_q   <= bus.req_wdata;
                poll_cnt  <= '0;
            end

            case (state)
                S_AHI, S_ALO: bus.irq <= bus.bus_din[0];
                S_STAT: begin
                    bus.resp_skip <= bus.bus_din[0];
                    if (!bus_ready && poll_cnt != POLL_LAST)
                        poll_cnt <= poll_cnt + PW'(1);
                end
                S_RD0: rd_hi[7:4] <= bus.bus_din;
                S_RD1: rd_hi[3:0] <= bus.bus_din;
                S_RD2: bus.resp_rdata <= {rd_hi, bus.bus_din};
                default: ;
            endcase

            // reaching DONE straight from STAT can only mean the poll gave up
            if (state_nxt == S_DONE)
                bus.resp_err <= (state == S_STAT);
        end
    end
endmodule
